// File: rtl/emu_host_pkg.sv
// Shared types and defaults for the emulator host sequencer.
package emu_host_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN_IN,
    ST_RUN_OUT,
    ST_DONE
  } seq_state_e;

  localparam logic SEQ_OP_LOAD = 1'b0;
  localparam logic SEQ_OP_RUN  = 1'b1;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/emu_host_sequencer.sv
// Command-driven LOAD/RUN sequencer between host streams and the emulator io_host port.
// Optional stall counter built when EMU_SEQ_STALL_CNT_EN is defined.
module emu_host_sequencer
  import emu_host_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_op,
  input  logic [CNT_W-1:0]    cmd_arg,
  input  logic                abort,
  input  logic                src_valid,
  output logic                src_ready,
  input  logic [2*DATA_W-1:0] src_bits,
  output logic                insns_valid,
  input  logic                insns_ready,
  output logic [DATA_W-1:0]   insns_bits_0,
  output logic [DATA_W-1:0]   insns_bits_1,
  output logic                io_i_valid,
  input  logic                io_i_ready,
  output logic [DATA_W-1:0]   io_i_bits,
  input  logic                io_o_valid,
  output logic                io_o_ready,
  input  logic [DATA_W-1:0]   io_o_bits,
  output logic                sink_valid,
  input  logic                sink_ready,
  output logic [DATA_W-1:0]   sink_bits,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic [31:0]         stall_cycles
);

  seq_state_e       state, state_d;
  logic [CNT_W-1:0] target;
  logic [CNT_W-1:0] next_cnt;
  logic             accept;
  logic             cnt_inc;

  // beat_cnt never exceeds target-1 before the compare, so this cannot wrap
  assign next_cnt = beat_cnt + 1'b1;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      target   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        target   <= cmd_arg;
        beat_cnt <= '0;
      end else if (cnt_inc) begin
        beat_cnt <= next_cnt;
      end
    end
  end

  always_comb begin
    state_d      = state;
    accept       = 1'b0;
    cnt_inc      = 1'b0;
    cmd_ready    = 1'b0;
    src_ready    = 1'b0;
    insns_valid  = 1'b0;
    insns_bits_0 = '0;
    insns_bits_1 = '0;
    io_i_valid   = 1'b0;
    io_i_bits    = '0;
    io_o_ready   = 1'b0;
    sink_valid   = 1'b0;
    sink_bits    = '0;
    done         = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept = 1'b1;
          if (cmd_arg == '0)             state_d = ST_DONE;
          else if (cmd_op == SEQ_OP_RUN) state_d = ST_RUN_IN;
          else                           state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        insns_valid  = src_valid && !abort;
        src_ready    = insns_ready && !abort;
        insns_bits_0 = src_bits[DATA_W-1:0];
        insns_bits_1 = src_bits[2*DATA_W-1:DATA_W];
        if (abort) begin
          state_d = ST_IDLE;
        end else if (src_valid && insns_ready) begin
          cnt_inc = 1'b1;
          if (next_cnt == target) state_d = ST_DONE;
        end
      end
      ST_RUN_IN: begin
        io_i_valid = src_valid && !abort;
        src_ready  = io_i_ready && !abort;
        io_i_bits  = src_bits[DATA_W-1:0];
        if (abort)                         state_d = ST_IDLE;
        else if (src_valid && io_i_ready)  state_d = ST_RUN_OUT;
      end
      ST_RUN_OUT: begin
        sink_valid = io_o_valid && !abort;
        io_o_ready = sink_ready && !abort;
        sink_bits  = io_o_bits;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (io_o_valid && sink_ready) begin
          cnt_inc = 1'b1;
          state_d = (next_cnt == target) ? ST_DONE : ST_RUN_IN;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef EMU_SEQ_STALL_CNT_EN
  logic stall_now;

  // Emulator-side handshake of the active state offered but not taken
  assign stall_now = (insns_valid && !insns_ready) ||
                     (io_i_valid && !io_i_ready) ||
                     ((state == ST_RUN_OUT) && io_o_valid && !abort && !io_o_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                         stall_cycles <= '0;
    else if (accept)                      stall_cycles <= '0;
    else if (stall_now && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_emu_host_sequencer.sv
// Directed self-checking bench for emu_host_sequencer.
module tb_emu_host_sequencer;
  import emu_host_pkg::*;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                cmd_valid = 1'b0, cmd_op = 1'b0;
  logic [CNT_W-1:0]    cmd_arg = '0;
  logic                abort = 1'b0;
  logic                src_valid = 1'b0;
  logic [2*DATA_W-1:0] src_bits = '0;
  logic                insns_ready = 1'b0, io_i_ready = 1'b0;
  logic                io_o_valid = 1'b0, sink_ready = 1'b0;
  logic [DATA_W-1:0]   io_o_bits = '0;
  logic                cmd_ready, src_ready, insns_valid, io_i_valid, io_o_ready;
  logic                sink_valid, busy, done;
  logic [DATA_W-1:0]   insns_bits_0, insns_bits_1, io_i_bits, sink_bits;
  logic [CNT_W-1:0]    beat_cnt;
  logic [31:0]         stall_cycles;

  int vec = 0;
  int errs = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc;

  emu_host_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .abort(abort),
    .src_valid(src_valid), .src_ready(src_ready), .src_bits(src_bits),
    .insns_valid(insns_valid), .insns_ready(insns_ready),
    .insns_bits_0(insns_bits_0), .insns_bits_1(insns_bits_1),
    .io_i_valid(io_i_valid), .io_i_ready(io_i_ready), .io_i_bits(io_i_bits),
    .io_o_valid(io_o_valid), .io_o_ready(io_o_ready), .io_o_bits(io_o_bits),
    .sink_valid(sink_valid), .sink_ready(sink_ready), .sink_bits(sink_bits),
    .busy(busy), .done(done), .beat_cnt(beat_cnt), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic test_reset();
    #2;
    vec++; if (busy !== 1'b0)     begin errs++; $display("FAIL reset_busy got %b exp 0", busy); end
    vec++; if (done !== 1'b0)     begin errs++; $display("FAIL reset_done got %b exp 0", done); end
    vec++; if (beat_cnt !== '0)   begin errs++; $display("FAIL reset_beat_cnt got %0d exp 0", beat_cnt); end
    vec++; if (stall_cycles !== 32'd0) begin errs++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock); #1;
    vec++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_load3();
    logic [15:0] b0 [3];
    logic [15:0] b1 [3];
    b0 = '{16'h0001, 16'h0003, 16'h0005};
    b1 = '{16'h0002, 16'h0004, 16'h0006};
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = SEQ_OP_LOAD; cmd_arg = 16'd3; insns_ready = 1'b1; acc = cyc; #1;
    vec++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL load_cmd_ready got %b exp 1", cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      cmd_valid = 1'b0; src_valid = 1'b1; src_bits = {b1[i], b0[i]}; #1;
      vec++; if (insns_valid !== 1'b1) begin errs++; $display("FAIL load_valid[%0d] got %b exp 1", i, insns_valid); end
      vec++; if (src_ready !== 1'b1)   begin errs++; $display("FAIL load_src_ready[%0d] got %b exp 1", i, src_ready); end
      vec++; if (insns_bits_0 !== b0[i]) begin errs++; $display("FAIL load_bits0[%0d] got %h exp %h", i, insns_bits_0, b0[i]); end
      vec++; if (insns_bits_1 !== b1[i]) begin errs++; $display("FAIL load_bits1[%0d] got %h exp %h", i, insns_bits_1, b1[i]); end
      vec++; if (done !== 1'b0) begin errs++; $display("FAIL load_early_done[%0d] got %b exp 0", i, done); end
    end
    @(negedge clock); src_valid = 1'b0; #1;
    vec++; if (done !== 1'b1)       begin errs++; $display("FAIL load_done got %b exp 1", done); end
    vec++; if (cyc - acc !== 4)     begin errs++; $display("FAIL load_latency got %0d exp 4", cyc - acc); end
    vec++; if (beat_cnt !== 16'd3)  begin errs++; $display("FAIL load_beat_cnt got %0d exp 3", beat_cnt); end
    vec++; if (insns_valid !== 1'b0) begin errs++; $display("FAIL load_done_valid got %b exp 0", insns_valid); end
    @(negedge clock); #1;
    vec++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL load_idle got done=%b busy=%b exp 0 0", done, busy); end
    insns_ready = 1'b0;
  endtask

  task automatic test_run2();
    logic [15:0] win [2];
    int d0;
    win = '{16'hA5A5, 16'h5A5A};
    d0 = done_cnt;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = SEQ_OP_RUN; cmd_arg = 16'd2; io_i_ready = 1'b1; sink_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      cmd_valid = 1'b0; io_o_valid = 1'b0; src_valid = 1'b1; src_bits = {16'h0000, win[i]}; #1;
      vec++; if (io_i_valid !== 1'b1) begin errs++; $display("FAIL run_in_valid[%0d] got %b exp 1", i, io_i_valid); end
      vec++; if (io_i_bits !== win[i]) begin errs++; $display("FAIL run_in_bits[%0d] got %h exp %h", i, io_i_bits, win[i]); end
      vec++; if (sink_valid !== 1'b0 || io_o_ready !== 1'b0) begin errs++; $display("FAIL run_in_outside got sink_valid=%b io_o_ready=%b exp 0 0", sink_valid, io_o_ready); end
      @(negedge clock);
      src_valid = 1'b0; io_o_valid = 1'b1; io_o_bits = win[i] + 16'd1; #1;
      vec++; if (sink_valid !== 1'b1) begin errs++; $display("FAIL run_out_valid[%0d] got %b exp 1", i, sink_valid); end
      vec++; if (sink_bits !== win[i] + 16'd1) begin errs++; $display("FAIL run_out_bits[%0d] got %h exp %h", i, sink_bits, win[i] + 16'd1); end
      vec++; if (io_i_valid !== 1'b0 || io_o_ready !== 1'b1) begin errs++; $display("FAIL run_out_hs got io_i_valid=%b io_o_ready=%b exp 0 1", io_i_valid, io_o_ready); end
      vec++; if (done !== 1'b0) begin errs++; $display("FAIL run_early_done[%0d] got %b exp 0", i, done); end
    end
    @(negedge clock); io_o_valid = 1'b0; #1;
    vec++; if (done !== 1'b1)      begin errs++; $display("FAIL run_done got %b exp 1", done); end
    vec++; if (beat_cnt !== 16'd2) begin errs++; $display("FAIL run_beat_cnt got %0d exp 2", beat_cnt); end
    @(negedge clock); #1;
    vec++; if (done_cnt - d0 !== 1) begin errs++; $display("FAIL run_done_pulses got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_stall();
    int exp_stall;
`ifdef EMU_SEQ_STALL_CNT_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = SEQ_OP_RUN; cmd_arg = 16'd1; io_i_ready = 1'b1; sink_ready = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0; src_valid = 1'b1; src_bits = 32'h0000_0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      src_valid = 1'b0; io_o_valid = 1'b1; io_o_bits = 16'h0011; #1;
      vec++; if (io_o_ready !== 1'b0) begin errs++; $display("FAIL stall_io_o_ready[%0d] got %b exp 0", i, io_o_ready); end
    end
    @(negedge clock); sink_ready = 1'b1; #1;
    vec++; if (io_o_ready !== 1'b1) begin errs++; $display("FAIL stall_release got %b exp 1", io_o_ready); end
    @(negedge clock); io_o_valid = 1'b0; #1;
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL stall_done got %b exp 1", done); end
    vec++; if (stall_cycles !== exp_stall) begin errs++; $display("FAIL stall_cycles got %0d exp %0d", stall_cycles, exp_stall); end
  endtask

  task automatic test_zero_arg();
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = SEQ_OP_LOAD; cmd_arg = 16'd0; src_valid = 1'b1; insns_ready = 1'b1; #1;
    vec++; if (insns_valid !== 1'b0) begin errs++; $display("FAIL zero_valid_accept got %b exp 0", insns_valid); end
    @(negedge clock); cmd_valid = 1'b0; #1;
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL zero_done got %b exp 1", done); end
    vec++; if (insns_valid !== 1'b0 || src_ready !== 1'b0) begin errs++; $display("FAIL zero_valid got valid=%b ready=%b exp 0 0", insns_valid, src_ready); end
    vec++; if (beat_cnt !== '0) begin errs++; $display("FAIL zero_beat_cnt got %0d exp 0", beat_cnt); end
    @(negedge clock); src_valid = 1'b0; insns_ready = 1'b0;
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = SEQ_OP_LOAD; cmd_arg = 16'd4; insns_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); cmd_valid = 1'b0; src_valid = 1'b1; src_bits = 32'h1111_2222 + i;
    end
    @(negedge clock); abort = 1'b1; #1;
    vec++; if (insns_valid !== 1'b0 || src_ready !== 1'b0) begin errs++; $display("FAIL abort_gate got valid=%b ready=%b exp 0 0", insns_valid, src_ready); end
    @(negedge clock); abort = 1'b0; src_valid = 1'b0; #1;
    vec++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errs++; $display("FAIL abort_idle got busy=%b cmd_ready=%b exp 0 1", busy, cmd_ready); end
    vec++; if (beat_cnt !== 16'd2) begin errs++; $display("FAIL abort_beat_cnt got %0d exp 2", beat_cnt); end
    vec++; if (done_cnt - d0 !== 0) begin errs++; $display("FAIL abort_done got %0d pulses exp 0", done_cnt - d0); end
    insns_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int guard;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = SEQ_OP_RUN; cmd_arg = 16'd3; io_i_ready = 1'b1; sink_ready = 1'b0;
    @(negedge clock); cmd_valid = 1'b0; src_valid = 1'b1; src_bits = 32'h0000_0042;
    @(negedge clock); src_valid = 1'b0; io_o_valid = 1'b1; sink_ready = 1'b1; #1;
    vec++; if (sink_valid !== 1'b1) begin errs++; $display("FAIL rst_pre_sink got %b exp 1", sink_valid); end
    #1 reset_n = 1'b0; #1;
    vec++; if (busy !== 1'b0 || sink_valid !== 1'b0 || io_o_ready !== 1'b0) begin errs++; $display("FAIL rst_async got busy=%b sink_valid=%b io_o_ready=%b exp 0 0 0", busy, sink_valid, io_o_ready); end
    vec++; if (beat_cnt !== '0 || done !== 1'b0) begin errs++; $display("FAIL rst_async_cnt got beat_cnt=%0d done=%b exp 0 0", beat_cnt, done); end
    io_o_valid = 1'b0; sink_ready = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b1; cmd_op = SEQ_OP_LOAD; cmd_arg = 16'd1; insns_ready = 1'b1; acc = cyc;
    @(negedge clock); cmd_valid = 1'b0; src_valid = 1'b1; src_bits = 32'hBEEF_CAFE; #1;
    vec++; if (insns_bits_0 !== 16'hCAFE || insns_bits_1 !== 16'hBEEF) begin errs++; $display("FAIL rst_load_bits got %h %h exp cafe beef", insns_bits_0, insns_bits_1); end
    guard = 0;
    @(negedge clock); src_valid = 1'b0; #1;
    while (done !== 1'b1 && guard < 20) begin @(negedge clock); #1; guard++; end
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL rst_load_done got timeout exp done"); end
    vec++; if (cyc - acc !== 2) begin errs++; $display("FAIL rst_load_latency got %0d exp 2", cyc - acc); end
    vec++; if (beat_cnt !== 16'd1) begin errs++; $display("FAIL rst_load_beat_cnt got %0d exp 1", beat_cnt); end
    insns_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load3();
    test_run2();
    test_stall();
    test_zero_arg();
    test_abort();
    test_reset_mid_run();
    @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/emu_host_sequencer.md
# emu_host_sequencer

Command-driven controller between the host wire/FIFO endpoints and the emulator's `io_host` port. It replaces host-side bit-banging of individual valid/ready wires. A LOAD command streams N instruction pairs into `insns`. A RUN command executes N host steps, each step pushing one `io_i` word and draining one `io_o` word. It sits in the FPGA top on the host clock, directly in front of the emulator top.

## Interface
- `DATA_W`, default 16: width of each instruction half and each I/O word.
- `CNT_W`, default 16: width of the command argument and of the counters.
- `clock`, input, 1: host clock. The whole block is on this single clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid` / `cmd_ready`, input / output, 1 each: command handshake.
- `cmd_op`, input, 1: 0 = LOAD, 1 = RUN.
- `cmd_arg`, input, CNT_W: beat count for LOAD, step count for RUN.
- `abort`, input, 1: synchronous cancel of the current command.
- `src_valid` / `src_ready`, input / output, 1 each: host data stream handshake.
- `src_bits`, input, 2*DATA_W: host data. For LOAD, `[DATA_W-1:0]` is bits_0 and the upper half is bits_1. For RUN, only the low half is used.
- `insns_valid` / `insns_ready`, output / input, 1 each: instruction handshake to the emulator.
- `insns_bits_0`, `insns_bits_1`, output, DATA_W each: instruction halves.
- `io_i_valid` / `io_i_ready`, output / input, 1 each: step-input handshake to the emulator.
- `io_i_bits`, output, DATA_W: step input word.
- `io_o_valid` / `io_o_ready`, input / output, 1 each: step-output handshake from the emulator.
- `io_o_bits`, input, DATA_W: step output word.
- `sink_valid` / `sink_ready`, output / input, 1 each: host result handshake.
- `sink_bits`, output, DATA_W: host result word.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse when a command completes.
- `beat_cnt`, output, CNT_W: beats or steps completed in the current or last command.
- `stall_cycles`, output, 32: stall counter. Present only under the configuration macro; see Configuration.

## Operation
- States: IDLE, LOAD, RUN_IN, RUN_OUT, DONE.
- IDLE:
  - `cmd_ready` = 1; all other handshake outputs are 0.
  - A command is accepted when `cmd_valid && cmd_ready`. On acceptance:
    - `cmd_arg` is latched into `target`.
    - `beat_cnt` is cleared to 0.
    - The next state is LOAD (op 0) or RUN_IN (op 1).
  - If `cmd_arg` == 0, the next state is DONE directly for either op. No data moves.
- LOAD (combinational pass-through, gated):
  - `insns_valid` = `src_valid && !abort`.
  - `src_ready` = `insns_ready && !abort`.
  - `insns_bits_*` are taken from `src_bits`.
  - Each transfer increments `beat_cnt`. When the transfer makes `beat_cnt` equal `target`, the next state is DONE.
- RUN_IN:
  - `io_i_valid` = `src_valid && !abort`.
  - `src_ready` = `io_i_ready && !abort`.
  - `io_i_bits` = `src_bits[DATA_W-1:0]`.
  - On transfer, the next state is RUN_OUT.
- RUN_OUT:
  - `sink_valid` = `io_o_valid && !abort`.
  - `io_o_ready` = `sink_ready && !abort`.
  - `sink_bits` = `io_o_bits`.
  - On transfer, `beat_cnt` increments. The next state is DONE if the new count equals `target`, otherwise RUN_IN.
- DONE: `done` = 1 for exactly one cycle, then the state returns to IDLE. `beat_cnt` holds its value until the next command is accepted.
- abort:
  - Honoured in LOAD, RUN_IN and RUN_OUT. All valid/ready outputs are forced to 0 in that cycle, so no transfer completes.
  - The next state is IDLE. `done` is not pulsed. `beat_cnt` holds the partial count.
  - abort is ignored in IDLE and in DONE.
- Counter arithmetic:
  - Counters are unsigned CNT_W and are compared for equality only.
  - `target` = 2^CNT_W-1 must be supported with no wrap before the completion compare.
- Bits outputs that are not selected by the current state drive 0.

## Timing
- Reset values: state IDLE, `beat_cnt` 0, `target` 0, `done` 0, `busy` 0, `stall_cycles` 0. `cmd_ready` is 1 from the first cycle after reset deassertion.
- Data paths are zero-latency pass-through; no data is stored in this block.
- LOAD throughput is 1 beat per cycle.
- RUN takes a minimum of 2 cycles per step: one for the io_i beat, one for the io_o beat.
- Command latency, minimum:
  - LOAD of N beats: accept cycle + N cycles + 1 DONE cycle. `done` is asserted N+1 cycles after the accept edge.
  - Zero-argument command: `done` is asserted 1 cycle after acceptance.
- Reset asserted mid-command returns to IDLE immediately (asynchronous). No `done` pulse is produced.

## Configuration
- `EMU_SEQ_STALL_CNT_EN` defined:
  - `stall_cycles` is a 32-bit counter.
  - It increments in every LOAD, RUN_IN or RUN_OUT cycle where the active path's valid is high and its ready is low. The active path is the emulator-side handshake of that state.
  - It saturates at 2^32-1 and clears when a command is accepted.
- Macro undefined: `stall_cycles` is tied to 0 and no counter logic is built.

## Structure
- Shared package `emu_host_pkg`:
  - State enum `seq_state_e`.
  - Op encodings `SEQ_OP_LOAD` = 1'b0 and `SEQ_OP_RUN` = 1'b1.
  - Default widths.
- No sub-module. The FSM, counters and muxing are a single module.

## Test plan
- LOAD with `cmd_arg`=3, source pairs {0x0001,0x0002}..{0x0005,0x0006}, `insns_ready` tied 1 → three beats, with matching bits_0/bits_1 on each, on consecutive cycles; `done` 4 cycles after accept; `beat_cnt`=3.
- RUN with `cmd_arg`=2, source words 0xA5A5 and 0x5A5A, emulator echoing input+1 → `io_i` sees 0xA5A5 then 0x5A5A; `sink` sees 0xA5A6 then 0x5A5B; order is strictly in, out, in, out; `done` once.
- RUN with `cmd_arg`=1, `sink_ready` held 0 for 5 cycles → `io_o_ready`=0 for those cycles; `stall_cycles`=5 with macro defined, 0 without it.
- LOAD with `cmd_arg`=0 → no `insns_valid` ever; `done` 1 cycle after accept; `beat_cnt`=0.
- LOAD with `cmd_arg`=4, abort asserted after 2 beats while `src_valid`=1 → no transfer in the abort cycle; state IDLE next cycle; no `done`; `beat_cnt`=2.
- `reset_n` low in the middle of RUN_OUT → outputs at reset values asynchronously; a fresh LOAD of 1 beat then completes normally.
